uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte-buffering stage directly upstream of UART_transmitter. Accepts bytes on a
//  valid/ready handshake, stores them in a FIFO and drives the transmitter's
//  i_bin/i_write_flag with fixed baud-paced timing, one byte per frame slot.
//  Lets producers burst bytes without tracking UART timing.
// PARAMETERS
//  CLK_FREQ      25000000  system clock frequency, Hz
//  BAUD_RATE     115200    line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide)
//  DEPTH         16        FIFO entries; power of 2, >= 2
//  WRITE_BITS    8         bit-times o_write_flag is held high per byte
//  GAP_BITS      2         bit-times o_write_flag is held low between bytes
// PORTS
//  i_clk         in   1            system clock, rising edge
//  i_rst_n       in   1            reset, asynchronous assert, active-low
//  i_data        in   8            byte to queue
//  i_valid       in   1            i_data valid; byte is accepted when i_valid && o_ready
//  o_ready       out  1            FIFO not full
//  o_bin         out  8            byte presented to transmitter (to i_bin)
//  o_write_flag  out  1            transmit strobe (to i_write_flag)
//  o_level       out  $clog2(DEPTH)+1   current FIFO occupancy
//  o_busy        out  1            FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset: o_bin=0, o_write_flag=0, o_level=0, o_ready=1, o_busy=0; FSM=IDLE, counters=0.
//   Reset mid-frame drops the current byte and flushes the FIFO. o_write_flag falls
//   asynchronously with reset.
//  FIFO: write on i_valid&&o_ready. o_ready=(o_level!=DEPTH), registered. Push while
//   full is ignored, even with a same-cycle pop. Push and pop in the same cycle
//   (not full) leaves o_level unchanged. Pointers wrap modulo DEPTH.
//  FSM states IDLE, SEND, GAP; cycle counter width $clog2(WRITE_BITS*CLKS_PER_BIT).
//   IDLE: when FIFO non-empty, pop the head. Next cycle: o_bin<=head,
//    o_write_flag<=1, ->SEND, counter<=0.
//   SEND: flag held high exactly WRITE_BITS*CLKS_PER_BIT cycles; o_bin stable
//    throughout. Then flag<=0 and ->GAP.
//   GAP: flag low exactly GAP_BITS*CLKS_PER_BIT cycles. Then: if FIFO non-empty, pop
//    and ->SEND with no extra idle cycle; else ->IDLE. o_bin keeps its last byte.
//  Latency: byte pushed into an empty FIFO with FSM IDLE at edge N -> o_write_flag=1
//   and o_bin valid after edge N+2.
//  Bytes leave in FIFO order; no byte is dropped or duplicated.
// CONFIGURATION
//  UART_TX_FEEDER_STATS_EN defined: adds outputs
//   o_sent_count [15:0]: counts SEND entries, wraps 0xFFFF->0.
//   o_overflow [1]: sticky, set when i_valid && !o_ready.
//   Both are cleared only by reset.
//  Not defined: these ports and their logic are absent. Core behaviour is identical.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] {IDLE,SEND,GAP} feeder_state_t;
//   function clks_per_bit(CLK_FREQ,BAUD_RATE); byte_t = logic [7:0].
//  Sub-module: sync_fifo (DEPTH, WIDTH=8; push/pop/full/empty/level).
//   The FSM and pacing counter stay in uart_tx_feeder.
// TESTING (bench with CLK_FREQ=40, BAUD_RATE=10 -> CLKS_PER_BIT=4; flag high 32 clk, gap 8 clk)
//  1 Reset: hold i_rst_n=0 -> all outputs at reset values. Release, no input -> IDLE forever, flag=0.
//  2 Push 0xA5 at edge N -> flag rises after N+2, high 32 cycles, o_bin=0xA5 throughout,
//    then low 8 cycles; FSM returns to IDLE.
//  3 Burst 0x01..0x05 back-to-back -> five 32-high/8-low slots, o_bin 01,02,03,04,05 in
//    order; o_level peaks at 4 or 5.
//  4 DEPTH=16: push 20 bytes while first frame is running -> o_ready drops at level 16;
//    extra pushes are ignored; all 16 accepted bytes go out in order.
//  5 Assert i_rst_n=0 at cycle 10 of SEND with 3 bytes queued -> flag falls at once;
//    after release, level=0 and nothing is sent.
//  6 STATS_EN: send 3 bytes and push 1 while full -> o_sent_count=3, o_overflow=1
//    until reset.
//  Pair with UART_receiver loopback: every sent byte must equal the received o_bin.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit feeder.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } feeder_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; a pop loads q on the next edge.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         q,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [LW-1:0]    level_next;
    logic             full_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && (level_reg != '0);

    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop_ok) begin
            level_next = level_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            full_reg  <= (level_next == LW'(DEPTH));
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data;
        end
        if (pop_ok) begin
            q_reg <= mem[rd_ptr_reg];
        end
    end

    assign q     = q_reg;
    assign full  = full_reg;
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and paces them into a UART transmitter, one strobed frame slot per byte.
// Optional statistics outputs are enabled by defining UART_TX_FEEDER_STATS_EN.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DEPTH      = 16,
    parameter int WRITE_BITS = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  byte_t                  i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output byte_t                  o_bin,
    output logic                   o_write_flag,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_busy
`ifdef UART_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]            o_sent_count,
    output logic                   o_overflow
`endif
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int WRITE_CYC = WRITE_BITS * CPB;
    localparam int GAP_CYC   = GAP_BITS * CPB;
    localparam int CNT_W     = (WRITE_CYC > 1) ? $clog2(WRITE_CYC) : 1;
    localparam int LVL_W     = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(WRITE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_POP   = CNT_W'(GAP_CYC - 2);

    feeder_state_t    state_reg;
    feeder_state_t    state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    byte_t            bin_reg;
    byte_t            bin_next;
    logic             flag_reg;
    logic             flag_next;
    logic             pending_reg;
    logic             pending_next;

    logic             fifo_push;
    logic             fifo_pop;
    byte_t            fifo_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    assign fifo_push = i_valid && !fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (fifo_push),
        .data  (i_data),
        .pop   (fifo_pop),
        .q     (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // pending marks a byte popped last cycle whose read data lands in fifo_q now.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bin_next     = bin_reg;
        flag_next    = flag_reg;
        pending_next = pending_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    bin_next     = fifo_q;
                    flag_next    = 1'b1;
                    cnt_next     = '0;
                    pending_next = 1'b0;
                    state_next   = SEND;
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    pending_next = 1'b1;
                end
            end
            SEND: begin
                if (cnt_reg == SEND_LAST) begin
                    flag_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (pending_reg) begin
                        bin_next     = fifo_q;
                        flag_next    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = SEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    // Pop one cycle early so the next frame starts right as the gap ends.
                    if ((cnt_reg == GAP_POP) && !fifo_empty) begin
                        fifo_pop     = 1'b1;
                        pending_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bin_reg     <= '0;
            flag_reg    <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bin_reg     <= bin_next;
            flag_reg    <= flag_next;
            pending_reg <= pending_next;
        end
    end

    assign o_ready      = !fifo_full;
    assign o_bin        = bin_reg;
    assign o_write_flag = flag_reg;
    assign o_level      = fifo_level;
    assign o_busy       = (state_reg != IDLE) || pending_reg || !fifo_empty;

`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] sent_count_reg;
    logic        overflow_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sent_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if ((state_next == SEND) && (state_reg != SEND)) begin
                sent_count_reg <= sent_count_reg + 16'd1;
            end
            if (i_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign o_sent_count = sent_count_reg;
    assign o_overflow   = overflow_reg;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus pushes expected bytes, a monitor checks frames.
module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int HIGH_CYC = 32;
    localparam int GAP_CYC  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] bin;
    logic       flag;
    logic [4:0] level;
    logic       busy;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] sent_count;
    logic        overflow;
`endif

    uart_tx_feeder #(
        .CLK_FREQ   (40),
        .BAUD_RATE  (10),
        .DEPTH      (DEPTH),
        .WRITE_BITS (8),
        .GAP_BITS   (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_bin        (bin),
        .o_write_flag (flag),
        .o_level      (level),
        .o_busy       (busy)
`ifdef UART_TX_FEEDER_STATS_EN
        ,
        .o_sent_count (sent_count),
        .o_overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes accepted but not yet seen on the line, plus stats.
    logic [7:0] exp_q[$];
    int         model_sent = 0;
    bit         model_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: frame boundaries and contents, sampled on the falling edge.
    bit         in_frame = 0;
    bit         have_fall = 0;
    bit         backlog = 0;
    bit         unstable = 0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] want;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 0;
            have_fall = 0;
            hi_cnt    = 0;
            lo_cnt    = 0;
        end else if (flag) begin
            if (!in_frame) begin
                if (have_fall) begin
                    check("gap_min", 32'(lo_cnt >= GAP_CYC), 1);
                    if (backlog) check("gap_exact", lo_cnt, GAP_CYC);
                end
                check("frame_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("frame_byte", bin, want);
                end
                $display("frame start byte=%02h", bin);
                in_frame = 1;
                hi_cnt   = 1;
                unstable = 0;
                cur_byte = bin;
            end else begin
                hi_cnt++;
                if (bin !== cur_byte) unstable = 1;
            end
        end else begin
            if (in_frame) begin
                check("high_len", hi_cnt, HIGH_CYC);
                check("bin_stable", 32'(unstable), 0);
                in_frame  = 0;
                have_fall = 1;
                lo_cnt    = 1;
                backlog   = (exp_q.size() > 0);
            end else begin
                lo_cnt++;
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit exp_acc, input string tag);
        data  = b;
        valid = 1'b1;
        check({tag, "_ready"}, 32'(ready), 32'(exp_acc));
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (exp_acc) begin
            exp_q.push_back(b);
            model_sent++;
        end else begin
            model_ovf = 1;
        end
        $display("push byte=%02h accept_expected=%0d", b, exp_acc);
    endtask

    task automatic check_stats(input string tag);
`ifdef UART_TX_FEEDER_STATS_EN
        check({tag, "_sent_count"}, sent_count, model_sent);
        check({tag, "_overflow"}, 32'(overflow), 32'(model_ovf));
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flag"}, 32'(flag), 0);
        check({tag, "_bin"}, bin, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check_stats(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        valid = 1'b0;
        exp_q.delete();
        model_sent = 0;
        model_ovf  = 0;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        $display("reset %s released", tag);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            idle(1);
        end
        check({tag, "_drain_busy"}, 32'(busy), 0);
        check({tag, "_drain_sb"}, exp_q.size(), 0);
        check({tag, "_drain_level"}, level, 0);
        check({tag, "_drain_flag"}, 32'(flag), 0);
        check_stats(tag);
    endtask

    task automatic wait_rise(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (flag) break;
            idle(1);
        end
        check({tag, "_rise"}, 32'(flag), 1);
    endtask

    int peak;
    int highs;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            if (flag || busy) highs++;
            idle(1);
        end
        check("t1_idle_quiet", highs, 0);

        // Latency: push at edge N, strobe high after N+2.
        push(8'hA5, 1, "t2");
        check("t2_level_n", level, 1);
        check("t2_flag_n", 32'(flag), 0);
        idle(1);
        check("t2_flag_n1", 32'(flag), 0);
        check("t2_level_n1", level, 0);
        check("t2_busy_n1", 32'(busy), 1);
        idle(1);
        check("t2_flag_n2", 32'(flag), 1);
        check("t2_bin_n2", bin, 8'hA5);
        wait_drain("t2", 200);

        // Back-to-back burst.
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), 1, "t3");
            if (int'(level) > peak) peak = int'(level);
        end
        check("t3_peak_level", peak, 4);
        wait_drain("t3", 400);

        // Random traffic, never exceeding model capacity.
        for (int it = 0; it < 40; it++) begin
            idle($urandom_range(0, 45));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                if (exp_q.size() < DEPTH) push(8'($urandom_range(0, 255)), 1, "rnd");
            end
        end
        wait_drain("rnd", 2000);

        // Stats: three bytes sent, no overflow.
        apply_reset("t6_reset");
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), 1, "t6");
        wait_drain("t6", 400);

        // Fill to DEPTH while the first frame runs; excess pushes are dropped.
        push(8'h80, 1, "t4");
        wait_rise("t4");
        for (int i = 0; i < 20; i++) push(8'h90 + 8'(i), i < DEPTH, "t4");
        check("t4_level_full", level, DEPTH);
        check("t4_ready_full", 32'(ready), 0);
        wait_drain("t4", 1200);

        // Reset in the middle of a frame with bytes queued.
        apply_reset("t5_pre");
        push(8'h11, 1, "t5");
        wait_rise("t5");
        for (int i = 0; i < 3; i++) push(8'h21 + 8'(i), 1, "t5");
        idle(7);
        check("t5_flag_before", 32'(flag), 1);
        apply_reset("t5_mid");
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            if (flag) highs++;
            idle(1);
        end
        check("t5_silent", highs, 0);
        check("t5_level", level, 0);
        check_stats("t5_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
